cr_huf_comp_sc_coalesce: RTL and testbench
==========================================

Name: cr_huf_comp_sc_coalesce

Overview:
Parametrised symbol coalescer for the Huffman compressor symbol-count path. Each input beat carries up to LANES symbols with a contiguous valid mask. The block merges duplicate symbols into unique-symbol/count pairs, packs them low-slot-first, and buffers the result in a FIFO for the input-stage consumer. Compared with the fixed 4-lane short coalescer, it adds: lane/width/depth parameters, a runtime dedup-bypass mode, a programmable ready margin, and sticky error flags.

Parameters:
LANES, 4, symbols per input beat (1..8)
SYM_W, 10, symbol width in bits
CNT_W, $clog2(LANES+1), per-slot count width (derived; do not override)
DEPTH, 256, FIFO entries (power of 2, at least 4)
RDY_MARGIN, 4, in_rdy is high only while free slots > RDY_MARGIN

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_dedup_en  in  1  1 = merge duplicates; 0 = bypass, every valid lane gets count 1
in_wr  in  1  input beat strobe
in_vld  in  LANES  lane valid mask; bit0 is the lowest lane
in_sym  in  LANES*SYM_W  lane symbols; lane i is in_sym[i*SYM_W +: SYM_W]
in_seq_id  in  4  sequence id, passed through
in_eob  in  2  e_pipe_eob code, passed through
in_rdy  out  1  free slots > RDY_MARGIN
out_rd  in  1  pop request
out_vld  out  1  FIFO not empty
out_sym  out  LANES*SYM_W  packed unique symbols
out_cnt  out  LANES*CNT_W  per-slot counts
out_num  out  CNT_W  number of occupied slots
out_seq_id  out  4  passed-through sequence id
out_eob  out  2  passed-through eob code
used_slots  out  $clog2(DEPTH+1)  FIFO occupancy
err_clr  in  1  clears both sticky errors
err_overflow  out  1  sticky; a write was attempted while the FIFO was full
err_vld_gap  out  1  sticky; in_vld was non-contiguous (form 0..01..1 violated)

Behaviour:
- Reset values: in_rdy=1, out_vld=0, used_slots=0, both errors 0. out_* data fields are 0 while the FIFO is empty.
- Stage 1 (combinational on the input):
  - Effective mask = in_vld truncated at the first 0 bit from bit0.
  - Dedup on: slot k holds the k-th distinct symbol in first-occurrence lane order; cnt[k] is its occurrence count among effective lanes.
  - Bypass: slot k = lane k, cnt=1.
  - Unused slots: sym=0, cnt=0. out_num = number of occupied slots; sum of cnt = popcount(effective mask).
- Stage 2 (register): on in_wr, the packed word {sym, cnt, num, seq_id, eob} is registered. The FIFO write happens the next cycle, so an input beat at cycle t is visible on out_vld at t+2.
- in_wr with in_vld=0 still writes an entry: num=0, all counts 0, seq_id and eob carried. This preserves eob markers.
- Non-contiguous in_vld: err_vld_gap is set the cycle after in_wr, and the truncated mask is used.
- in_rdy is advisory. A write when the FIFO is full is dropped, err_overflow is set, and FIFO state is unchanged.
- FIFO is first-word-fall-through: out_* show the head entry whenever out_vld=1.
  - out_rd with out_vld=1 pops the head; the next entry is presented the following cycle.
  - out_rd while empty is ignored and is not an error.
- Simultaneous write and pop: occupancy unchanged. This is legal when full (pop first) and when empty (the write lands; out_vld goes high next cycle).
- Pointers wrap modulo DEPTH. used_slots + free slots = DEPTH at all times.
- err_clr takes priority over a same-cycle error set.
- cfg_dedup_en is sampled with in_wr, per beat. Changing it mid-stream affects only later beats.
- Reset mid-operation: the FIFO empties, the stage-2 register is cleared, and a pending write is lost.

Decomposition:
- Shared package (cr_huf_compPKG): the packed-entry struct s_sc_coalesce_entry, parameterised via localparams for LANES/SYM_W, plus an LANES-max constant and e_pipe_eob reuse.
- Sub-module cr_huf_comp_sc_coalesce_fifo: generic FWFT register/RAM FIFO with parameters DEPTH and WIDTH, outputs used_slots/free_slots/full/empty.
- Dedup/pack logic is an always_comb loop (lanes × slots compare network) in the top module.

Test Plan:
- LANES=4, dedup on, vld=1111, syms {5,5,9,5} -> slots {5,9,0,0}, cnt {3,1,0,0}, num=2, first entry at t+2.
- vld=1111, syms {1,2,3,4}, bypass and dedup modes -> both give {1,2,3,4}, cnt {1,1,1,1}, num=4. Then syms {7,7,7,7} bypass -> cnt all 1, num=4; dedup -> {7}, cnt 4, num=1.
- vld=0101, syms {3,x,8,x} -> err_vld_gap=1; entry {3}, cnt 1, num=1. err_clr -> flag 0.
- in_wr, vld=0000, eob=2, seq_id=6 -> entry num=0, eob=2, seq_id=6.
- DEPTH=4: write 5 beats with no pops -> in_rdy low at free slots ≤ RDY_MARGIN, 5th beat dropped, err_overflow=1, used_slots=4, and 4 pops return beats 1-4 in order.
- Full FIFO with simultaneous write and pop for 10 cycles -> used_slots stays 4, no overflow, order preserved across pointer wrap. Reset asserted mid-stream -> out_vld=0, used_slots=0 on the next clk.

Source files
------------

// File: rtl/cr_huf_comp_sc_coalesce_pkg.sv
// Shared types for the symbol-count coalescer: eob codes, lane limits and the packed FIFO entry layout.
package cr_huf_comp_sc_coalesce_pkg;

   localparam int SC_LANES_MAX = 8;
   localparam int SC_LANES     = 4;
   localparam int SC_SYM_W     = 10;
   localparam int SC_CNT_W     = $clog2(SC_LANES + 1);

   typedef enum logic [1:0] {
      EOB_NONE  = 2'd0,
      EOB_BLK   = 2'd1,
      EOB_LAST  = 2'd2,
      EOB_FLUSH = 2'd3
   } e_pipe_eob;

   // Field order matches the packed word stored in the FIFO: {sym, cnt, num, seq_id, eob}.
   typedef struct packed {
      logic [SC_LANES-1:0][SC_SYM_W-1:0] sym;
      logic [SC_LANES-1:0][SC_CNT_W-1:0] cnt;
      logic [SC_CNT_W-1:0]               num;
      logic [3:0]                        seq_id;
      e_pipe_eob                         eob;
   } s_sc_coalesce_entry;

   function automatic int sc_entry_w(input int lanes, input int sym_w);
      return lanes * sym_w + (lanes + 1) * $clog2(lanes + 1) + 6;
   endfunction

endpackage

// File: rtl/cr_huf_comp_sc_coalesce_fifo.sv
// First-word-fall-through FIFO; a push while full is dropped unless a pop frees the slot the same cycle.
module cr_huf_comp_sc_coalesce_fifo #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       rd,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] used_slots,
   output logic [$clog2(DEPTH+1)-1:0] free_slots,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int UW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [UW-1:0]    cnt;
   logic             push;
   logic             pop;

   assign empty      = (cnt == '0);
   assign full       = (cnt == UW'(DEPTH));
   assign pop        = rd & ~empty;
   assign push       = wr & (~full | pop);
   assign overflow   = wr & full & ~pop;
   assign used_slots = cnt;
   assign free_slots = UW'(DEPTH) - cnt;
   assign rdata      = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         cnt <= cnt + UW'(push) - UW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/cr_huf_comp_sc_coalesce.sv
// Symbol coalescer: merges duplicate lane symbols into packed symbol/count slots and queues them in a FWFT FIFO.
module cr_huf_comp_sc_coalesce
   import cr_huf_comp_sc_coalesce_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int SYM_W      = 10,
   parameter int CNT_W      = $clog2(LANES + 1),
   parameter int DEPTH      = 256,
   parameter int RDY_MARGIN = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_dedup_en,
   input  logic                       in_wr,
   input  logic [LANES-1:0]           in_vld,
   input  logic [LANES*SYM_W-1:0]     in_sym,
   input  logic [3:0]                 in_seq_id,
   input  logic [1:0]                 in_eob,
   output logic                       in_rdy,
   input  logic                       out_rd,
   output logic                       out_vld,
   output logic [LANES*SYM_W-1:0]     out_sym,
   output logic [LANES*CNT_W-1:0]     out_cnt,
   output logic [CNT_W-1:0]           out_num,
   output logic [3:0]                 out_seq_id,
   output logic [1:0]                 out_eob,
   output logic [$clog2(DEPTH+1)-1:0] used_slots,
   input  logic                       err_clr,
   output logic                       err_overflow,
   output logic                       err_vld_gap
);

   localparam int UW    = $clog2(DEPTH + 1);
   localparam int ENT_W = LANES * SYM_W + LANES * CNT_W + CNT_W + 6;

   logic [LANES-1:0]       eff_p0;
   logic                   gap_p0;
   logic                   run_p0;
   logic                   dup_p0;
   logic [LANES*SYM_W-1:0] sym_p0;
   logic [LANES*CNT_W-1:0] cnt_p0;
   logic [CNT_W-1:0]       num_p0;
   logic [CNT_W-1:0]       lane_slot_p0 [LANES];
   e_pipe_eob              eob_p0;

   logic                   vld_p1;
   logic [ENT_W-1:0]       entry_p1;

   logic [ENT_W-1:0]       head;
   logic [UW-1:0]          free_slots;
   logic                   full;
   logic                   empty;
   logic                   overflow;

   assign eob_p0 = e_pipe_eob'(in_eob);

   // Stage 1: truncate the mask at the first hole, then pack lanes into slots in first-occurrence order.
   always_comb begin
      run_p0 = 1'b1;
      dup_p0 = 1'b0;
      sym_p0 = '0;
      cnt_p0 = '0;
      num_p0 = '0;
      for (int i = 0; i < LANES; i++) begin
         run_p0          = run_p0 & in_vld[i];
         eff_p0[i]       = run_p0;
         lane_slot_p0[i] = '0;
      end
      gap_p0 = |(in_vld & ~eff_p0);
      for (int i = 0; i < LANES; i++) begin
         if (eff_p0[i]) begin
            if (!cfg_dedup_en) begin
               sym_p0[i*SYM_W +: SYM_W] = in_sym[i*SYM_W +: SYM_W];
               cnt_p0[i*CNT_W +: CNT_W] = CNT_W'(1);
               num_p0                   = num_p0 + CNT_W'(1);
            end else begin
               // Earlier effective lanes are all valid, so a match points at an already-allocated slot.
               dup_p0          = 1'b0;
               lane_slot_p0[i] = num_p0;
               for (int j = 0; j < i; j++) begin
                  if (!dup_p0 && (in_sym[j*SYM_W +: SYM_W] == in_sym[i*SYM_W +: SYM_W])) begin
                     dup_p0          = 1'b1;
                     lane_slot_p0[i] = lane_slot_p0[j];
                  end
               end
               if (!dup_p0) begin
                  sym_p0[num_p0*SYM_W +: SYM_W] = in_sym[i*SYM_W +: SYM_W];
                  num_p0                        = num_p0 + CNT_W'(1);
               end
               cnt_p0[lane_slot_p0[i]*CNT_W +: CNT_W] =
                  cnt_p0[lane_slot_p0[i]*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end

   // Stage 2: register the packed entry; empty beats are kept so eob markers reach the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         entry_p1 <= '0;
      end else begin
         vld_p1 <= in_wr;
         if (in_wr) entry_p1 <= {sym_p0, cnt_p0, num_p0, in_seq_id, eob_p0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overflow <= 1'b0;
         err_vld_gap  <= 1'b0;
      end else if (err_clr) begin
         err_overflow <= 1'b0;
         err_vld_gap  <= 1'b0;
      end else begin
         if (overflow)         err_overflow <= 1'b1;
         if (in_wr && gap_p0)  err_vld_gap  <= 1'b1;
      end
   end

   cr_huf_comp_sc_coalesce_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (vld_p1),
      .wdata      (entry_p1),
      .rd         (out_rd),
      .rdata      (head),
      .used_slots (used_slots),
      .free_slots (free_slots),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow)
   );

   assign in_rdy  = ~full & (32'(free_slots) > RDY_MARGIN);
   assign out_vld = ~empty;
   assign {out_sym, out_cnt, out_num, out_seq_id, out_eob} = head;

endmodule

// File: tb/tb_cr_huf_comp_sc_coalesce.sv
// Bench for the symbol coalescer: directed vector table, overflow/wrap/reset sequences, random traffic vs. a queue model.
module tb_cr_huf_comp_sc_coalesce;

   localparam int LANES      = 4;
   localparam int SYM_W      = 10;
   localparam int CNT_W      = 3;
   localparam int DEPTH      = 4;
   localparam int RDY_MARGIN = 1;
   localparam int UW         = 3;

   typedef struct packed {
      logic [3:0][9:0] sym;
      logic [3:0][2:0] cnt;
      logic [2:0]      num;
      logic [3:0]      seq;
      logic [1:0]      eob;
   } ent_t;

   typedef struct {
      logic            dd;
      logic [3:0]      v;
      logic [3:0][9:0] s;
      logic [3:0]      sq;
      logic [1:0]      eb;
      logic [3:0][9:0] xs;
      logic [3:0][2:0] xc;
      logic [2:0]      xn;
      logic            xg;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            t_dd, t_wr, t_rd, t_clr;
   logic [3:0]      t_vld;
   logic [3:0][9:0] t_sym;
   logic [3:0]      t_seq;
   logic [1:0]      t_eob;
   logic            in_rdy, out_vld, err_overflow, err_vld_gap;
   logic [39:0]     out_sym;
   logic [11:0]     out_cnt;
   logic [2:0]      out_num;
   logic [3:0]      out_seq_id;
   logic [1:0]      out_eob;
   logic [UW-1:0]   used_slots;

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t q[$];
   ent_t pend;
   logic pend_v;
   logic m_ovf, m_gap;
   vec_t tbl[9];

   always #5 clk = ~clk;

   cr_huf_comp_sc_coalesce #(
      .LANES      (LANES),
      .SYM_W      (SYM_W),
      .DEPTH      (DEPTH),
      .RDY_MARGIN (RDY_MARGIN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_dedup_en (t_dd),
      .in_wr        (t_wr),
      .in_vld       (t_vld),
      .in_sym       (t_sym),
      .in_seq_id    (t_seq),
      .in_eob       (t_eob),
      .in_rdy       (in_rdy),
      .out_rd       (t_rd),
      .out_vld      (out_vld),
      .out_sym      (out_sym),
      .out_cnt      (out_cnt),
      .out_num      (out_num),
      .out_seq_id   (out_seq_id),
      .out_eob      (out_eob),
      .used_slots   (used_slots),
      .err_clr      (t_clr),
      .err_overflow (err_overflow),
      .err_vld_gap  (err_vld_gap)
   );

   function automatic logic [3:0][9:0] pk4(input int a, input int b, input int c, input int d);
      logic [3:0][9:0] r;
      r[0] = 10'(a); r[1] = 10'(b); r[2] = 10'(c); r[3] = 10'(d);
      return r;
   endfunction

   function automatic logic [3:0][2:0] pc4(input int a, input int b, input int c, input int d);
      logic [3:0][2:0] r;
      r[0] = 3'(a); r[1] = 3'(b); r[2] = 3'(c); r[3] = 3'(d);
      return r;
   endfunction

   // Reference: unique symbols listed by first appearance, each count found by scanning all effective lanes.
   function automatic ent_t model(input logic dd, input logic [3:0] v, input logic [3:0][9:0] s,
                                  input logic [3:0] sq, input logic [1:0] eb, output logic g);
      ent_t e;
      int   n, u, c;
      logic seen;
      e = '0;
      n = 0;
      while (n < 4 && v[n]) n++;
      g = ((v >> n) != 4'd0);
      if (dd) begin
         u = 0;
         for (int i = 0; i < n; i++) begin
            seen = 1'b0;
            for (int k = 0; k < u; k++) if (e.sym[k] == s[i]) seen = 1'b1;
            if (!seen) begin e.sym[u] = s[i]; u++; end
         end
         for (int k = 0; k < u; k++) begin
            c = 0;
            for (int i = 0; i < n; i++) if (s[i] == e.sym[k]) c++;
            e.cnt[k] = 3'(c);
         end
         e.num = 3'(u);
      end else begin
         for (int i = 0; i < n; i++) begin e.sym[i] = s[i]; e.cnt[i] = 3'd1; end
         e.num = 3'(n);
      end
      e.seq = sq;
      e.eob = eb;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic set_in(input logic wr, input logic rd, input logic dd, input logic [3:0] v,
                         input logic [3:0][9:0] s, input logic [3:0] sq, input logic [1:0] eb,
                         input logic clr);
      t_wr = wr; t_rd = rd; t_dd = dd; t_vld = v; t_sym = s; t_seq = sq; t_eob = eb; t_clr = clr;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 1'b1, 4'h0, '0, 4'h0, 2'd0, 1'b0);
   endtask

   // Advance one clock from a falling edge, stepping the model with the inputs currently driven.
   task automatic cyc();
      ent_t e, h;
      logic g, ovf_set;
      e       = model(t_dd, t_vld, t_sym, t_seq, t_eob, g);
      ovf_set = 1'b0;
      if (t_rd && q.size() > 0) void'(q.pop_front());
      if (pend_v) begin
         if (q.size() < DEPTH) q.push_back(pend);
         else ovf_set = 1'b1;
      end
      if (t_clr) begin
         m_ovf = 1'b0; m_gap = 1'b0;
      end else begin
         if (ovf_set)     m_ovf = 1'b1;
         if (t_wr && g)   m_gap = 1'b1;
      end
      pend_v = t_wr;
      pend   = e;
      @(posedge clk);
      @(negedge clk);
      h = (q.size() > 0) ? q[0] : '0;
      chk("out_vld", out_vld, q.size() > 0);
      chk("used_slots", used_slots, q.size());
      chk("in_rdy", in_rdy, (DEPTH - q.size()) > RDY_MARGIN);
      chk("out_sym", out_sym, h.sym);
      chk("out_cnt", out_cnt, h.cnt);
      chk("out_num", out_num, h.num);
      chk("out_seq_id", out_seq_id, h.seq);
      chk("out_eob", out_eob, h.eob);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_vld_gap", err_vld_gap, m_gap);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_async out_vld", out_vld, 1'b0);
      chk("rst_async used", used_slots, 0);
      q.delete();
      pend_v = 1'b0;
      m_ovf  = 1'b0;
      m_gap  = 1'b0;
      idle();
      @(posedge clk);
      @(negedge clk);
      chk("rst_clk out_vld", out_vld, 1'b0);
      chk("rst_clk used", used_slots, 0);
      chk("rst_clk in_rdy", in_rdy, 1'b1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      pend_v = 1'b0;
      m_ovf  = 1'b0;
      m_gap  = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      chk("reset in_rdy", in_rdy, 1'b1);
      chk("reset out_vld", out_vld, 1'b0);
      chk("reset used", used_slots, 0);
      chk("reset err_overflow", err_overflow, 1'b0);
      chk("reset err_vld_gap", err_vld_gap, 1'b0);
      chk("reset out_sym", out_sym, 0);
      rst_n = 1'b1;

      tbl[0] = '{1'b1, 4'b1111, pk4(5,5,9,5),         4'd1, 2'd0, pk4(5,9,0,0),      pc4(3,1,0,0), 3'd2, 1'b0};
      tbl[1] = '{1'b0, 4'b1111, pk4(1,2,3,4),         4'd2, 2'd1, pk4(1,2,3,4),      pc4(1,1,1,1), 3'd4, 1'b0};
      tbl[2] = '{1'b1, 4'b1111, pk4(1,2,3,4),         4'd3, 2'd0, pk4(1,2,3,4),      pc4(1,1,1,1), 3'd4, 1'b0};
      tbl[3] = '{1'b0, 4'b1111, pk4(7,7,7,7),         4'd4, 2'd0, pk4(7,7,7,7),      pc4(1,1,1,1), 3'd4, 1'b0};
      tbl[4] = '{1'b1, 4'b1111, pk4(7,7,7,7),         4'd5, 2'd3, pk4(7,0,0,0),      pc4(4,0,0,0), 3'd1, 1'b0};
      tbl[5] = '{1'b1, 4'b0101, pk4(3,11,8,12),       4'd7, 2'd0, pk4(3,0,0,0),      pc4(1,0,0,0), 3'd1, 1'b1};
      tbl[6] = '{1'b1, 4'b0000, pk4(1,2,3,4),         4'd6, 2'd2, pk4(0,0,0,0),      pc4(0,0,0,0), 3'd0, 1'b0};
      tbl[7] = '{1'b0, 4'b0111, pk4(9,9,2,5),         4'd8, 2'd1, pk4(9,9,2,0),      pc4(1,1,1,0), 3'd3, 1'b0};
      tbl[8] = '{1'b1, 4'b0011, pk4(1023,1023,4,4),   4'd15,2'd0, pk4(1023,0,0,0),   pc4(2,0,0,0), 3'd1, 1'b0};

      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         set_in(1'b1, 1'b0, tbl[i].dd, tbl[i].v, tbl[i].s, tbl[i].sq, tbl[i].eb, 1'b0);
         cyc();
         chk($sformatf("vec%0d latency t+1", i), out_vld, 1'b0);
         idle();
         cyc();
         chk($sformatf("vec%0d out_vld", i), out_vld, 1'b1);
         chk($sformatf("vec%0d sym", i), out_sym, tbl[i].xs);
         chk($sformatf("vec%0d cnt", i), out_cnt, tbl[i].xc);
         chk($sformatf("vec%0d num", i), out_num, tbl[i].xn);
         chk($sformatf("vec%0d seq", i), out_seq_id, tbl[i].sq);
         chk($sformatf("vec%0d eob", i), out_eob, tbl[i].eb);
         chk($sformatf("vec%0d gap", i), err_vld_gap, tbl[i].xg);
         set_in(1'b0, 1'b1, 1'b1, 4'h0, '0, 4'h0, 2'd0, 1'b1);
         cyc();
         chk($sformatf("vec%0d gap cleared", i), err_vld_gap, 1'b0);
      end
      idle();
      t_rd = 1'b1;
      cyc();

      // Overflow: five beats into a four-entry FIFO with no pops.
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         set_in(1'b1, 1'b0, 1'b0, 4'b1111, pk4(k, k+10, k+20, k+30), 4'(k), 2'd0, 1'b0);
         cyc();
      end
      idle();
      cyc();
      cyc();
      chk("ovf used_slots", used_slots, 4);
      chk("ovf flag", err_overflow, 1'b1);
      chk("ovf in_rdy", in_rdy, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ovf pop%0d sym", k), out_sym, pk4(k, k+10, k+20, k+30));
         chk($sformatf("ovf pop%0d seq", k), out_seq_id, k);
         set_in(1'b0, 1'b1, 1'b0, 4'h0, '0, 4'h0, 2'd0, 1'b0);
         cyc();
      end
      chk("ovf drained", out_vld, 1'b0);
      set_in(1'b0, 1'b1, 1'b0, 4'h0, '0, 4'h0, 2'd0, 1'b1);
      cyc();
      chk("ovf cleared", err_overflow, 1'b0);

      // Refill, then stream write+pop while full across pointer wrap; reset lands mid-stream.
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, 1'b0, 1'b0, 4'b1111, pk4(100+k, 0, 0, 0), 4'(k), 2'd1, 1'b0);
         cyc();
      end
      chk("full before stream", used_slots, 4);
      for (int k = 5; k < 15; k++) begin
         set_in(1'b1, 1'b1, 1'b0, 4'b1111, pk4(100+k, 0, 0, 0), 4'(k), 2'd1, 1'b0);
         cyc();
         chk($sformatf("stream%0d used", k), used_slots, 4);
         chk($sformatf("stream%0d head", k), out_sym, pk4(100+k-4, 0, 0, 0));
         chk($sformatf("stream%0d no ovf", k), err_overflow, 1'b0);
      end
      do_reset();

      // Random traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         logic [3:0][9:0] s;
         for (int i = 0; i < 4; i++)
            s[i] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 3));
         set_in($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), s, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 19) == 0);
         cyc();
         if (n == 300) do_reset();
      end
      idle();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
